// File: rtl/axil_regfile.sv
// axil_regfile
//   AXI4-Lite slave register file. It holds NUM_REGS data-wide registers
//   written with byte strobes. Registers selected by RO_MASK are read-only
//   and read back their hw_status slice. An out-of-range address, or a write
//   to a read-only register, is answered with SLVERR. The AW and W channels
//   are captured independently, so they may arrive in either order.
//
// Ports
//   s0_axi_aclk, s0_axi_aresetn   clock; synchronous active-low reset
//   s0_axi_aw*/w*/b*              write address, data and response channels
//   s0_axi_ar*/r*                 read address and data channels
//   hw_status                     read-only register values, slice i = register i
//   reg_out                       current register contents, slice i = register i
//   wr_pulse                      one-cycle strobe per register after an OKAY write
module axil_regfile #(
    parameter int                      DATA_WIDTH = 32,
    parameter int                      ADDR_WIDTH = 8,
    parameter int                      NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]     RO_MASK    = '0
) (
    input  logic                           s0_axi_aclk,
    input  logic                           s0_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s0_axi_awaddr,
    input  logic                           s0_axi_awvalid,
    output logic                           s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s0_axi_wstrb,
    input  logic                           s0_axi_wvalid,
    output logic                           s0_axi_wready,
    output logic [1:0]                     s0_axi_bresp,
    output logic                           s0_axi_bvalid,
    input  logic                           s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s0_axi_araddr,
    input  logic                           s0_axi_arvalid,
    output logic                           s0_axi_arready,
    output logic [DATA_WIDTH-1:0]          s0_axi_rdata,
    output logic [1:0]                     s0_axi_rresp,
    output logic                           s0_axi_rvalid,
    input  logic                           s0_axi_rready,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int OFF       = $clog2(NUM_BYTES);
    localparam int IDX_W     = ADDR_WIDTH - OFF;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Holds the readies low until the first cycle after reset is released.
    logic rdy_en;

    logic                  aw_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  w_held;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [NUM_BYTES-1:0]  w_strb_q;

    logic aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [NUM_BYTES-1:0]  cur_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [NUM_REGS-1:0]   wr_sel;
    logic                  wr_legal;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_legal;

    assign s0_axi_awready = rdy_en && !aw_held && !s0_axi_bvalid;
    assign s0_axi_wready  = rdy_en && !w_held  && !s0_axi_bvalid;
    assign s0_axi_arready = rdy_en && !s0_axi_rvalid;

    assign aw_hs = s0_axi_awvalid && s0_axi_awready;
    assign w_hs  = s0_axi_wvalid  && s0_axi_wready;
    assign ar_hs = s0_axi_arvalid && s0_axi_arready;

    // A channel handshaking this cycle counts as available for the commit.
    assign commit   = (aw_held || aw_hs) && (w_held || w_hs);
    assign cur_addr = aw_held ? aw_addr_q : s0_axi_awaddr;
    assign cur_data = w_held  ? w_data_q  : s0_axi_wdata;
    assign cur_strb = w_held  ? w_strb_q  : s0_axi_wstrb;

    assign wr_idx = cur_addr[ADDR_WIDTH-1:OFF];
    assign rd_idx = s0_axi_araddr[ADDR_WIDTH-1:OFF];

    // Byte-offset bits are intentionally ignored by the decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s0_axi_araddr, cur_addr};

    always_comb begin
        wr_sel   = '0;
        wr_legal = 1'b0;
        rd_data  = '0;
        rd_legal = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i) && !RO_MASK[i]) begin
                wr_sel[i] = 1'b1;
                wr_legal  = 1'b1;
            end
            if (rd_idx == IDX_W'(i)) begin
                rd_legal = 1'b1;
                rd_data  = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
            end
        end
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (!s0_axi_aresetn) begin
            rdy_en        <= 1'b0;
            aw_held       <= 1'b0;
            aw_addr_q     <= '0;
            w_held        <= 1'b0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s0_axi_bvalid <= 1'b0;
            s0_axi_bresp  <= RESP_OKAY;
            s0_axi_rvalid <= 1'b0;
            s0_axi_rresp  <= RESP_OKAY;
            s0_axi_rdata  <= '0;
            wr_pulse      <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            rdy_en   <= 1'b1;
            wr_pulse <= '0;

            if (commit) begin
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                s0_axi_bvalid <= 1'b1;
                s0_axi_bresp  <= wr_legal ? RESP_OKAY : RESP_SLVERR;
                wr_pulse      <= wr_sel;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_sel[i]) begin
                        for (int b = 0; b < NUM_BYTES; b++) begin
                            if (cur_strb[b]) begin
                                regs[i][b*8 +: 8] <= cur_data[b*8 +: 8];
                            end
                        end
                    end
                end
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= s0_axi_awaddr;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= s0_axi_wdata;
                    w_strb_q <= s0_axi_wstrb;
                end
            end

            if (s0_axi_bvalid && s0_axi_bready) begin
                s0_axi_bvalid <= 1'b0;
            end

            // Register reads see the pre-commit value on a same-edge write.
            if (ar_hs) begin
                s0_axi_rvalid <= 1'b1;
                s0_axi_rdata  <= rd_data;
                s0_axi_rresp  <= rd_legal ? RESP_OKAY : RESP_SLVERR;
            end else if (s0_axi_rvalid && s0_axi_rready) begin
                s0_axi_rvalid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_axil_regfile.sv
module tb_axil_regfile;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h0020;   // register 5 is read-only

    logic              clk;
    logic              aresetn;
    logic [AW-1:0]     awaddr;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [NR*DW-1:0]  hw_status;
    logic [NR*DW-1:0]  reg_out;
    logic [NR-1:0]     wr_pulse;

    logic [NR*DW-1:0]  exp_out;
    int n_cmp = 0;
    int n_err = 0;

    axil_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(RO)) dut (
        .s0_axi_aclk    (clk),
        .s0_axi_aresetn (aresetn),
        .s0_axi_awaddr  (awaddr),
        .s0_axi_awvalid (awvalid),
        .s0_axi_awready (awready),
        .s0_axi_wdata   (wdata),
        .s0_axi_wstrb   (wstrb),
        .s0_axi_wvalid  (wvalid),
        .s0_axi_wready  (wready),
        .s0_axi_bresp   (bresp),
        .s0_axi_bvalid  (bvalid),
        .s0_axi_bready  (bready),
        .s0_axi_araddr  (araddr),
        .s0_axi_arvalid (arvalid),
        .s0_axi_arready (arready),
        .s0_axi_rdata   (rdata),
        .s0_axi_rresp   (rresp),
        .s0_axi_rvalid  (rvalid),
        .s0_axi_rready  (rready),
        .hw_status      (hw_status),
        .reg_out        (reg_out),
        .wr_pulse       (wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_both(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic b_done(input string tag);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk(tag, bvalid, 1'b0);
    endtask

    task automatic read_chk(input string tag, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [1:0] r);
        araddr  = a;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk({tag, "_rvalid"}, rvalid, 1'b1);
        chk({tag, "_rdata"}, rdata, d);
        chk({tag, "_rresp"}, rresp, r);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk({tag, "_rdone"}, rvalid, 1'b0);
    endtask

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        hw_status = '0;
        hw_status[5*DW +: DW] = 32'hCAFE0001;
        hw_status[1*DW +: DW] = 32'hBAD00001;   // must be ignored: reg 1 is writable
        exp_out = '0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_reg_out", reg_out, exp_out);
        chk("rst_pulse", wr_pulse, 16'h0);
        aresetn = 1'b1;
        tick();
        chk("rel_awready", awready, 1'b1);
        chk("rel_wready", wready, 1'b1);
        chk("rel_arready", arready, 1'b1);

        // 1: AW and W together
        write_both(8'h04, 32'hDEADBEEF, 4'hF);
        exp_out[1*DW +: DW] = 32'hDEADBEEF;
        chk("t1_bvalid", bvalid, 1'b1);
        chk("t1_bresp", bresp, 2'b00);
        chk("t1_reg", reg_out, exp_out);
        chk("t1_pulse", wr_pulse, 16'h0002);
        chk("t1_awready_busy", awready, 1'b0);
        b_done("t1_bdone");
        chk("t1_pulse_gone", wr_pulse, 16'h0000);
        chk("t1_awready_back", awready, 1'b1);
        read_chk("t1_rd", 8'h04, 32'hDEADBEEF, 2'b00);

        // 2a: W first, AW three cycles later
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("t2a_wready_held", wready, 1'b0);
        chk("t2a_no_commit0", bvalid, 1'b0);
        tick(); tick();
        chk("t2a_no_commit1", bvalid, 1'b0);
        chk("t2a_reg_before", reg_out, exp_out);
        awaddr = 8'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        exp_out[2*DW +: DW] = 32'h00220044;
        chk("t2a_bvalid", bvalid, 1'b1);
        chk("t2a_reg", reg_out, exp_out);
        chk("t2a_pulse", wr_pulse, 16'h0004);
        b_done("t2a_bdone");

        // 2b: AW first (register 6), W three cycles later
        awaddr = 8'h18; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("t2b_awready_held", awready, 1'b0);
        tick(); tick();
        chk("t2b_no_commit", bvalid, 1'b0);
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        exp_out[6*DW +: DW] = 32'h00220044;
        chk("t2b_bvalid", bvalid, 1'b1);
        chk("t2b_reg", reg_out, exp_out);
        chk("t2b_pulse", wr_pulse, 16'h0040);
        b_done("t2b_bdone");

        // 3: out of range and read-only
        write_both(8'h40, 32'h01020304, 4'hF);
        chk("t3_oor_bvalid", bvalid, 1'b1);
        chk("t3_oor_bresp", bresp, 2'b10);
        chk("t3_oor_pulse", wr_pulse, 16'h0);
        chk("t3_oor_reg", reg_out, exp_out);
        b_done("t3_oor_bdone");
        read_chk("t3_oor_rd", 8'h40, 32'h0, 2'b10);
        write_both(8'h14, 32'h55555555, 4'hF);
        chk("t3_ro_bresp", bresp, 2'b10);
        chk("t3_ro_pulse", wr_pulse, 16'h0);
        chk("t3_ro_reg", reg_out, exp_out);
        b_done("t3_ro_bdone");
        read_chk("t3_ro_rd", 8'h14, 32'hCAFE0001, 2'b00);

        // wstrb = 0 to a legal register: OKAY, pulse, no data change
        write_both(8'h10, 32'hFFFFFFFF, 4'h0);
        chk("zs_bresp", bresp, 2'b00);
        chk("zs_pulse", wr_pulse, 16'h0010);
        chk("zs_reg", reg_out, exp_out);
        b_done("zs_bdone");

        // 4: B and R backpressure
        write_both(8'h1C, 32'hA5A5A5A5, 4'hF);
        exp_out[7*DW +: DW] = 32'hA5A5A5A5;
        for (int i = 0; i < 5; i++) begin
            chk("t4_bvalid_hold", bvalid, 1'b1);
            chk("t4_bresp_hold", bresp, 2'b00);
            chk("t4_awready_low", awready, 1'b0);
            chk("t4_wready_low", wready, 1'b0);
            tick();
        end
        b_done("t4_bdone");
        araddr = 8'h1C; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_rvalid_hold", rvalid, 1'b1);
            chk("t4_rdata_hold", rdata, 32'hA5A5A5A5);
            chk("t4_arready_low", arready, 1'b0);
            tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("t4_rdone", rvalid, 1'b0);
        chk("t4_arready_back", arready, 1'b1);

        // 5: reset with B and R pending and AW/W held high
        write_both(8'h28, 32'h0BADF00D, 4'hF);
        chk("t5_bpend", bvalid, 1'b1);
        araddr = 8'h28; arvalid = 1'b1;
        awaddr = 8'h20; awvalid = 1'b1; wdata = 32'h66666666; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("t5_rpend", rvalid, 1'b1);
        aresetn = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        exp_out = '0;
        chk("t5_bvalid", bvalid, 1'b0);
        chk("t5_rvalid", rvalid, 1'b0);
        chk("t5_reg", reg_out, exp_out);
        chk("t5_awready", awready, 1'b0);
        aresetn = 1'b1;
        tick();
        chk("t5_awready_rel", awready, 1'b1);
        // Partially accepted W must be discarded by reset
        wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        awaddr = 8'h24; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("t5_w_dropped0", bvalid, 1'b0);
        tick();
        chk("t5_w_dropped1", bvalid, 1'b0);
        chk("t5_w_dropped_reg", reg_out, exp_out);
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        exp_out[9*DW +: DW] = 32'h12345678;
        chk("t5_fresh_bvalid", bvalid, 1'b1);
        chk("t5_fresh_bresp", bresp, 2'b00);
        chk("t5_fresh_reg", reg_out, exp_out);
        chk("t5_fresh_pulse", wr_pulse, 16'h0200);
        b_done("t5_fresh_bdone");

        // 6: same-edge write and read of register 3
        write_both(8'h0C, 32'h9, 4'hF);
        b_done("t6_pre_bdone");
        araddr = 8'h0C; arvalid = 1'b1;
        awaddr = 8'h0C; awvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        exp_out[3*DW +: DW] = 32'h5;
        chk("t6_rdata_old", rdata, 32'h9);
        chk("t6_rresp", rresp, 2'b00);
        chk("t6_reg_new", reg_out, exp_out);
        chk("t6_pulse", wr_pulse, 16'h0008);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        chk("t6_bdone", bvalid, 1'b0);
        read_chk("t6_rd_new", 8'h0C, 32'h5, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
Parametrised AXI4-Lite slave register file on the s0_axi_ port set. It provides NUM_REGS word-wide registers with byte-strobe writes, per-register read-only selection, and SLVERR responses for out-of-range or illegal accesses. AW and W channels are accepted independently, so address and data may arrive in either order. It sits between the interconnect and block-level control/status logic, which it drives through flat register outputs and single-cycle write pulses.

Parameters:
DATA_WIDTH, 32, data bus width in bits; multiple of 8
ADDR_WIDTH, 8, byte address width
NUM_REGS, 16, number of registers; 1..2**(ADDR_WIDTH-log2(DATA_WIDTH/8))
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only (value taken from hw_status)

Ports:
s0_axi_aclk  in  1  clock
s0_axi_aresetn  in  1  reset, synchronous, active-low
s0_axi_awaddr  in  ADDR_WIDTH  write byte address
s0_axi_awvalid  in  1  write address valid
s0_axi_awready  out  1  write address ready
s0_axi_wdata  in  DATA_WIDTH  write data
s0_axi_wstrb  in  DATA_WIDTH/8  byte enables
s0_axi_wvalid  in  1  write data valid
s0_axi_wready  out  1  write data ready
s0_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
s0_axi_bvalid  out  1  write response valid
s0_axi_bready  in  1  write response ready
s0_axi_araddr  in  ADDR_WIDTH  read byte address
s0_axi_arvalid  in  1  read address valid
s0_axi_arready  out  1  read address ready
s0_axi_rdata  out  DATA_WIDTH  read data
s0_axi_rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
s0_axi_rvalid  out  1  read data valid
s0_axi_rready  in  1  read data ready
hw_status  in  NUM_REGS*DATA_WIDTH  read-only values; slice i for register i
reg_out  out  NUM_REGS*DATA_WIDTH  current register contents; slice i for register i
wr_pulse  out  NUM_REGS  one-cycle strobe, bit i set for each OKAY write to register i

Behaviour:
- Clock and reset: one clock, s0_axi_aclk. Reset is s0_axi_aresetn, synchronous and active-low.
- Reset values: every ready/valid output is 0, bresp and rresp are 0, rdata is 0, every reg_out slice is 0, wr_pulse is 0, and both holding flags are cleared. Readies rise in the first cycle after reset deasserts.
- Reset mid-operation: any partially accepted AW or W is discarded, and any pending B or R response is dropped with no handshake.
- Address decode: idx = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]. The low byte-offset bits are ignored.
- awready = 1 while no address is held and bvalid = 0. wready = 1 while no data is held and bvalid = 0.
- A handshake on AW or W latches that channel and sets its holding flag. The channels may handshake in the same cycle or in either order.
- Commit happens at the clock edge where both the address and the data are available, counting the handshake occurring in that cycle.
  - If idx < NUM_REGS and RO_MASK[idx] = 0: each byte b with wstrb[b] = 1 is updated, and wr_pulse[idx] = 1 for exactly the next cycle. bresp = OKAY.
  - Otherwise: no register changes and no pulse. bresp = SLVERR.
  - bvalid rises in the cycle after commit, and both holding flags clear.
- bvalid and bresp hold until bvalid && bready. awready and wready are 0 while bvalid = 1.
- Write latency: AW and W handshaking together in cycle T gives reg_out updated, wr_pulse and bvalid all in cycle T+1. Next write acceptance is the cycle after the B handshake.
- wstrb = 0 with a legal address is an OKAY response, no data change, and a pulse still fires.
- Read: arready = 1 while rvalid = 0. An AR handshake in cycle T gives rvalid, rdata and rresp valid in cycle T+1.
  - idx < NUM_REGS: returns hw_status[idx] if RO_MASK[idx] = 1, else the register value, with rresp = OKAY.
  - idx >= NUM_REGS: rdata = 0, rresp = SLVERR.
  - rdata and rresp are held stable until rvalid && rready. arready returns to 1 in the following cycle.
- Read and write channels are fully independent. A read and a commit to the same register at the same edge return the pre-write value.
- hw_status is sampled at the AR handshake edge.

Test Plan:
1. Reset, then AW and W in the same cycle: addr 0x04, wdata 0xDEADBEEF, wstrb 4'hF -> cycle T+1 shows bvalid = 1, bresp = 00, reg_out slice 1 = 0xDEADBEEF, wr_pulse = 16'h0002 for one cycle. Read 0x04 -> rdata 0xDEADBEEF, rresp 00.
2. W first (0x11223344, wstrb 4'b0101), AW to 0x08 three cycles later -> no commit before AW arrives; reg 2 goes from 0 to 0x00220044. Also run with AW first and the same result is required.
3. Write and read to 0x40 with NUM_REGS = 16 -> bresp = 10 and rresp = 10, rdata = 0, no register or pulse change. Write to a RO_MASK register -> SLVERR; read of it returns the hw_status value 0xCAFE0001.
4. bready held 0 for 5 cycles after a write -> bvalid and bresp stable, awready = wready = 0 throughout. Same check for rready = 0 on R: rdata stable.
5. Assert reset with AW held and B pending -> next cycle all valids = 0, reg_out = 0. After release, a fresh write completes normally.
6. Same-edge write of 0x5 and read of register 3 (old value 0x9) -> rdata = 0x9; a subsequent read returns 0x5.
